mult_booth: RTL and testbench
=============================

// Module: mult_booth
// PURPOSE
//   Sequential signed multiplier using radix-2 Booth's algorithm. It is the
//   companion of the iterative divider in the ALU's HI/LO datapath.
//   The control unit pulses start with two signed operands. 32 cycles later
//   the block writes the 64-bit product into hi (upper word) and lo (lower
//   word) and pulses done. Used for MULT; the result is read by MFHI/MFLO.
// PARAMETERS
//   WIDTH  32  operand width in bits; product width is 2*WIDTH
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   reset  in   1      asynchronous, active-low reset (0 = reset asserted)
//   start  in   1      request; sampled on a rising clk edge while IDLE
//   a      in   WIDTH  multiplicand, two's complement
//   b      in   WIDTH  multiplier, two's complement
//   busy   out  1      high while an operation is in progress (state RUN)
//   done   out  1      one-cycle pulse; hi/lo are valid in this cycle
//   hi     out  WIDTH  product[2*WIDTH-1:WIDTH]
//   lo     out  WIDTH  product[WIDTH-1:0]
// BEHAVIOUR
//   Reset (reset==0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0,
//     all internal registers cleared. Reset mid-RUN aborts the operation and
//     produces no done. After release, start is sampled on the first rising edge.
//   Internal regs:
//     M[WIDTH:0]   multiplicand, sign-extended by one bit
//     A[WIDTH:0]   accumulator, sign-extended by one bit
//     Q[WIDTH-1:0] multiplier / product low word
//     q_1          extra low bit
//     cnt          counter, $clog2(WIDTH)+1 bits
//   FSM, two states:
//     IDLE: if start, latch M={a[MSB],a}, A=0, Q=b, q_1=0, cnt=WIDTH;
//           busy=1; go to RUN. hi/lo keep their last result (not cleared).
//     RUN: one Booth step per clock:
//       {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged.
//       Then arithmetic right shift of {A,Q,q_1} by 1; A[WIDTH] is replicated.
//       cnt=cnt-1. On the edge where cnt goes 1->0, the final shifted values load:
//       hi=A[WIDTH-1:0], lo=Q, done=1, busy=0, next state IDLE.
//   done is cleared on the next edge. It is never high for two consecutive
//     cycles unless a new op completes.
//   Latency: start is sampled at edge E0; done and the new hi/lo become visible
//     after edge E32 (WIDTH edges). busy is high from E0 to E32.
//   start while busy: ignored; operands are not re-latched; the current op continues.
//   start in the cycle done is high: the state is IDLE, so it is accepted
//     (back-to-back ops, no dead cycle).
//   Width rule: the one-bit guard in A/M makes A-M exact for a = -2^(WIDTH-1).
//     No overflow is possible; the result is the exact signed 2*WIDTH product.
//   a and b are only sampled on acceptance. Changes during RUN have no effect.
// TESTING
//   T1: a=7, b=6, start 1 cycle -> after 32 edges done=1, hi=0, lo=42; busy
//       drops on the same edge.
//   T2: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
//   T3: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x7FFFFFFF,
//       b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
//   T4: start with a=3, b=4. Pulse start with a=9, b=9 at cycle 5 -> result
//       hi=0, lo=12, exactly one done.
//   T5: start a=5, b=5. Assert reset low mid-cycle at cycle 10 -> hi=lo=0,
//       busy=0, done=0 immediately; no done follows. After release, a=2, b=-2
//       -> hi=0xFFFFFFFF, lo=0xFFFFFFFC.
//   T6: a=0, b=0x12345678 -> hi=lo=0. Then start held high with a=-1, b=-1 in
//       the done cycle -> accepted; 32 edges later hi=0, lo=1.

Source files
------------

// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth
//   Sequential signed multiplier using radix-2 Booth recoding, one step per
//   clock. It is the multiply half of the ALU's HI/LO datapath. A start pulse
//   taken while idle latches the two's-complement operands. WIDTH clock edges
//   later the exact 2*WIDTH-bit product is written to hi/lo, and done pulses
//   for one cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-low reset
//   start  in   1      operation request, honoured only while idle
//   a      in   WIDTH  multiplicand, two's complement
//   b      in   WIDTH  multiplier, two's complement
//   busy   out  1      high while an operation is running
//   done   out  1      one-cycle pulse; hi/lo are valid in this cycle
//   hi     out  WIDTH  upper word of the product
//   lo     out  WIDTH  lower word of the product
// -----------------------------------------------------------------------------
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   m_next;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             q_1;
  logic             q_1_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // Booth step datapath
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             q_1_sh;

  // Booth recoding of the pair {Q[0], q_1}: 01 adds M, 10 subtracts M,
  // 00/11 leave the accumulator alone. The extra guard bit in acc/m keeps
  // acc - m exact even for the most negative multiplicand.
  function automatic logic [WIDTH:0] booth_add(
    input logic [WIDTH:0] acc_in,
    input logic [WIDTH:0] m_in,
    input logic [1:0]     sel
  );
    logic [WIDTH:0] res;
    case (sel)
      2'b01:   res = acc_in + m_in;
      2'b10:   res = acc_in - m_in;
      default: res = acc_in;
    endcase
    return res;
  endfunction

  // One Booth add/subtract followed by an arithmetic right shift of {acc,q,q_1}
  always_comb begin
    sum    = booth_add(acc, m, {q[0], q_1});
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh   = {sum[0], q[WIDTH-1:1]};
    q_1_sh = q[0];
  end

  // Next-state and next-register logic for the IDLE/RUN controller
  always_comb begin
    state_next = state;
    m_next     = m;
    acc_next   = acc;
    q_next     = q;
    q_1_next   = q_1;
    cnt_next   = cnt;
    busy_next  = busy;
    done_next  = 1'b0;
    hi_next    = hi;
    lo_next    = lo;

    case (state)
      IDLE: begin
        if (start) begin
          m_next     = {a[WIDTH-1], a};
          acc_next   = '0;
          q_next     = b;
          q_1_next   = 1'b0;
          cnt_next   = CNT_LOAD;
          busy_next  = 1'b1;
          state_next = RUN;
        end else begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      RUN: begin
        acc_next = acc_sh;
        q_next   = q_sh;
        q_1_next = q_1_sh;
        cnt_next = cnt - CNT_ONE;
        // Last step: publish the freshly shifted product. acc_sh[WIDTH] is
        // only a sign copy and is not part of the product.
        if (cnt == CNT_ONE) begin
          hi_next    = acc_sh[WIDTH-1:0];
          lo_next    = q_sh;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      m     <= m_next;
      acc   <= acc_next;
      q     <= q_next;
      q_1   <= q_1_next;
      cnt   <= cnt_next;
      busy  <= busy_next;
      done  <= done_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// -----------------------------------------------------------------------------
// tb_mult_booth
//   Self-checking bench for mult_booth. Table-driven operand/product records
//   are applied in a loop; expected products are queued when an operation is
//   started and popped by a monitor whenever done is seen. Hand-written
//   sequences cover start-while-busy, reset mid-run and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_booth #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          total;
  int          bad;
  int          done_cnt;
  int          n;
  int          dc0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest queued product
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("product", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Wait (bounded) for done; returns number of edges waited
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (done !== 1'b1 && cycles < 40);
  endtask

  // Start one op from posedge+#1, check latency, busy drop, single done pulse
  task automatic run_op(input vec_t v);
    int c;
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    sb.push_back({v.eh, v.el});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("busy_after_start", busy, 1'b1);
    wait_done(c);
    check("latency", c, 32);
    check("busy_at_done", busy, 1'b0);
    @(posedge clk);
    #1;
    check("done_pulse_one_cycle", done, 1'b0);
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.a = va; v.b = vb; v.eh = eh; v.el = el;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   ra;
    int   rb;
    longint p;

    total = 0; bad = 0; done_cnt = 0;
    reset = 1'b0; start = 1'b0; a = '0; b = '0;

    tbl.push_back(mk(32'd7,          32'd6,          32'h00000000, 32'd42));
    tbl.push_back(mk(32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1));
    tbl.push_back(mk(32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000));
    tbl.push_back(mk(32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001));
    tbl.push_back(mk(32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000));
    tbl.push_back(mk(32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001));
    tbl.push_back(mk(32'h00000000,   32'hFFFFFFFF,   32'h00000000, 32'h00000000));
    tbl.push_back(mk(32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000));
    for (int i = 0; i < 4; i++) begin
      ra = int'($urandom);
      rb = int'($urandom);
      p  = longint'(ra) * longint'(rb);
      tbl.push_back(mk(ra, rb, p[63:32], p[31:0]));
    end

    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven products; first op is requested on the first edge after release
    foreach (tbl[i]) run_op(tbl[i]);

    // Start while busy is ignored
    start = 1'b1; a = 32'd3; b = 32'd4;
    sb.push_back({32'h0, 32'd12});
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
    check("busy_ignores_start", busy, 1'b1);
    wait_done(n);
    check("latency_busy_start", n, 27);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("single_done", done_cnt - dc0, 1);

    // Reset mid-run aborts the operation
    start = 1'b1; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dc0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - dc0, 0);
    check("idle_after_abort", busy, 1'b0);
    run_op(mk(32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC));

    // Back-to-back: start held in the done cycle is accepted
    start = 1'b1; a = 32'd0; b = 32'h12345678;
    sb.push_back(64'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("latency_b2b_first", n, 32);
    start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    sb.push_back(64'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accepted", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    wait_done(n);
    check("latency_b2b_second", n, 32);
    @(posedge clk);
    #1;

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
